// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring divider for DIV/DIVU in the execute stage.
// A request is accepted in IDLE, then the FSM runs 32 shift/subtract steps,
// applies the sign fix-up, and pulses result_ready for one cycle in DONE.
// A zero divisor short-circuits through DIVZERO and yields an all-zero result.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   div_valid    execute-stage instruction is DIV/DIVU (held while stalled)
//   signed_div   1 = DIV (signed), 0 = DIVU; sampled with div_valid
//   opdata1      dividend (rs)
//   opdata2      divisor (rt)
//   annul        pipeline flush; cancels a pending request or operation
//   stall_div    hold the instruction in execute (combinational)
//   result       {remainder -> HI, quotient -> LO}, registered
//   result_ready one-cycle HI/LO write enable (combinational from DONE)

module div_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic        stall_div,
    output logic [63:0] result,
    output logic        result_ready
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DIVZERO = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DW-1:0]     r_q;
    logic [DW-1:0]     q_q;
    logic [DW-1:0]     b_q;
    logic              sa_q;
    logic              sb_q;
    logic [CW-1:0]     cnt_q;
    logic [2*DW-1:0]   result_q;

    logic              accept;
    logic              last_step;
    logic              sa_in;
    logic              sb_in;
    logic [DW-1:0]     mag_a;
    logic [DW-1:0]     mag_b;
    logic [DW:0]       r_shift;
    logic              qbit;
    logic [DW-1:0]     r_step;
    logic [DW-1:0]     q_step;
    logic [DW-1:0]     quot_fix;
    logic [DW-1:0]     rem_fix;

    // Request acceptance and operand magnitudes
    always_comb begin
        accept = (state == S_IDLE) && div_valid && !annul;
        sa_in  = signed_div & opdata1[DW-1];
        sb_in  = signed_div & opdata2[DW-1];
        mag_a  = sa_in ? (DW'(0) - opdata1) : opdata1;
        mag_b  = sb_in ? (DW'(0) - opdata2) : opdata2;
    end

    // One restoring step plus sign fix-up of that step's outcome.
    // The partial remainder always stays below the divisor, so 32 bits hold it;
    // only the shifted value needs the extra bit for the compare.
    always_comb begin
        last_step = (cnt_q == CW'(DW - 1));
        r_shift   = {r_q, q_q[DW-1]};
        qbit      = (r_shift >= {1'b0, b_q});
        r_step    = qbit ? DW'(r_shift - {1'b0, b_q}) : r_shift[DW-1:0];
        q_step    = {q_q[DW-2:0], qbit};
        quot_fix  = (sa_q ^ sb_q) ? (DW'(0) - q_step) : q_step;
        rem_fix   = sa_q ? (DW'(0) - r_step) : r_step;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2 == '0) ? S_DIVZERO : S_RUN;
                end
            end
            S_RUN: begin
                if (annul) begin
                    state_nxt = S_IDLE;
                end else if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DIVZERO: begin
                state_nxt = annul ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, and result capture on entry to DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        b_q   <= mag_b;
                        q_q   <= mag_a;
                        r_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!annul) begin
                        r_q <= r_step;
                        q_q <= q_step;
                        if (last_step) begin
                            result_q <= {rem_fix, quot_fix};
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_DIVZERO: begin
                    if (!annul) begin
                        result_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stall drops in the annul cycle itself so the flush is not held back
    always_comb begin
        stall_div    = accept
                     || ((state == S_RUN) && !annul)
                     || ((state == S_DIVZERO) && !annul);
        result_ready = (state == S_DONE) && !annul;
        result       = result_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with hand-computed expected results.

module tb_div_sequencer;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall_div;
    logic [63:0] result;
    logic        result_ready;

    int checks;
    int failures;

    div_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_valid    (div_valid),
        .signed_div   (signed_div),
        .opdata1      (opdata1),
        .opdata2      (opdata2),
        .annul        (annul),
        .stall_div    (stall_div),
        .result       (result),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one divide at T0 (just after a rising edge), count stall cycles
    // until result_ready, check the result and the cycle after DONE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [63:0] exp_res);
        int  stalls;
        bit  seen;
        stalls = 0;
        seen   = 0;
        @(posedge clk); #1;
        div_valid  = 1'b1;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (result_ready) begin
                seen = 1;
                break;
            end
            if (stall_div) stalls++;
            @(posedge clk); #1;
        end
        check({tag, "_ready_seen"}, 64'(seen), 64'd1);
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        check({tag, "_stall_in_done"}, 64'(stall_div), 64'd0);
        check({tag, "_result"}, result, exp_res);
        div_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_ready_after"}, 64'(result_ready), 64'd0);
        check({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        div_valid  = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 64'h0);
        check("rst_stall", 64'(stall_div), 64'd0);
        check("rst_ready", 64'(result_ready), 64'd0);
        resetn = 1'b1;

        run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          33, 64'h00000002_0000000E);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          33, 64'hFFFFFFFF_FFFFFFFD);
        run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   33, 64'h00000001_FFFFFFFD);
        run_div("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 64'h00000000_80000000);
        run_div("divu_5_9",      1'b0, 32'd5,          32'd9,          33, 64'h00000005_00000000);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          33, 64'h00000000_FFFFFFFF);

        // Annul at T10 of DIVU 100/7: stall drops at once, nothing is written
        @(posedge clk); #1;
        div_valid  = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        annul     = 1'b1;
        div_valid = 1'b0;
        @(negedge clk);
        check("annul_stall_tn", 64'(stall_div), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0;
        begin
            int rdy_cnt;
            int stl_cnt;
            rdy_cnt = 0;
            stl_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (result_ready) rdy_cnt++;
                if (stall_div) stl_cnt++;
            end
            check("annul_no_ready", 64'(rdy_cnt), 64'd0);
            check("annul_no_stall", 64'(stl_cnt), 64'd0);
        end
        check("annul_result_kept", result, 64'h00000000_FFFFFFFF);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

        run_div("divzero", 1'b0, 32'h1234, 32'd0, 2, 64'h0);

        // Reset in the middle of an operation
        run_div("divu_100_7b", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
        @(posedge clk); #1;
        div_valid = 1'b1;
        opdata1   = 32'd1000;
        opdata2   = 32'd33;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        resetn    = 1'b0;
        div_valid = 1'b0;
        #1;
        check("midrst_result", result, 64'h0);
        check("midrst_stall", 64'(stall_div), 64'd0);
        check("midrst_ready", 64'(result_ready), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_div("divu_1000_33", 1'b0, 32'd1000, 32'd33, 33, 64'h0000000A_0000001E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
